// File: rtl/car_traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : car_traffic_pkg
//  Description : Shared types and constants for the car traffic generator.
//                Holds the FSM state encoding, the photo-sensor image
//                constants and a helper that maps a pass phase to its
//                sensor image.
//                Optional feature macro: CAR_TRAFFIC_GEN_ABORT_EN adds the
//                REV state that is used to back a car out of the sensors.
//  Revision    : 1.0 - initial release
// ============================================================================
package car_traffic_pkg;

    // FSM state encoding. REV only exists when the abort feature is built in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
        ,
        REV  = 3'd4
`endif
    } state_t;

    // Sensor image: bit1 = outer sensor A, bit0 = inner sensor B, 1 = blocked.
    localparam logic [1:0] SNS_CLEAR = 2'b00;
    localparam logic [1:0] SNS_A     = 2'b10;
    localparam logic [1:0] SNS_AB    = 2'b11;
    localparam logic [1:0] SNS_B     = 2'b01;

    // Sensor image shown while a pass sits in a given phase. An exit pass
    // is the mirror image of an enter pass, so only PH1/PH3 depend on dir.
    function automatic logic [1:0] phase_sensors(input state_t phase, input logic enter);
        logic [1:0] v;
        case (phase)
            PH1:     v = enter ? SNS_A : SNS_B;
            PH2:     v = SNS_AB;
            PH3:     v = enter ? SNS_B : SNS_A;
            default: v = SNS_CLEAR;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Loadable down-counter with a zero flag. Loading value N and
//                then decrementing once per cycle keeps the phase running for
//                N+1 cycles, including the cycle in which zero is seen.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset (count -> 0)
//                i_load     - load i_load_val (has priority over i_dec)
//                i_load_val - value to load
//                i_dec      - decrement by one, saturating at zero
//                o_zero     - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/car_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module      : car_traffic_gen
//  Description : Generates the photo-sensor image of one car passing a
//                two-beam gate. A pass is three phases (A, AB, B for an
//                enter pass; B, AB, A for an exit pass), each dwell+1
//                cycles long, followed by one clear cycle flagged by done.
//                Optional feature macro: CAR_TRAFFIC_GEN_ABORT_EN adds the
//                abort input / aborted output; an aborted car backs out
//                through the phases it has already crossed.
//  Ports       : clk     - clock, rising edge
//                reset   - synchronous active-high reset
//                start   - request one pass (accepted only when idle)
//                dir     - 1 = enter, 0 = exit
//                dwell   - phase length minus one, in cycles
//                sensors - registered sensor image {A, B}
//                busy    - pass in progress
//                done    - one-cycle pulse after a completed pass
//                abort   - (ABORT_EN) back the car out
//                aborted - (ABORT_EN) one-cycle pulse after a backed-out pass
//  Revision    : 1.0 - initial release
// ============================================================================
module car_traffic_gen
    import car_traffic_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sensors,
    output logic               busy,
    output logic               done
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
    ,
    input  logic               abort,
    output logic               aborted
`endif
);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic               r_dir;
    logic               w_dir_next;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_next;
    logic               r_done;
    logic               w_done_next;
    logic [1:0]         r_sensors;
    logic [1:0]         w_sensors_next;
    logic               r_busy;
    logic               w_busy_next;
    state_t             w_disp;

`ifdef CAR_TRAFFIC_GEN_ABORT_EN
    // Phase currently being replayed while backing out.
    state_t             r_rev_phase;
    state_t             w_rev_next;
    logic               r_aborted;
    logic               w_aborted_next;
`endif

    // Timer control
    logic               w_load;
    logic [DWELL_W-1:0] w_load_val;
    logic               w_dec;
    logic               w_zero;

    dwell_timer #(
        .WIDTH (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // ------------------------------------------------------------------
    // State register. Outputs are registered from their next values so
    // sensors/busy/done change in the same cycle as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_dwell     <= '0;
            r_done      <= 1'b0;
            r_sensors   <= SNS_CLEAR;
            r_busy      <= 1'b0;
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
            r_rev_phase <= PH1;
            r_aborted   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_dir       <= w_dir_next;
            r_dwell     <= w_dwell_next;
            r_done      <= w_done_next;
            r_sensors   <= w_sensors_next;
            r_busy      <= w_busy_next;
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
            r_rev_phase <= w_rev_next;
            r_aborted   <= w_aborted_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Each phase loads the timer on entry and leaves
    // when the timer reads zero, giving dwell+1 cycles per phase.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_dir_next     = r_dir;
        w_dwell_next   = r_dwell;
        w_done_next    = 1'b0;
        w_load         = 1'b0;
        w_load_val     = r_dwell;
        w_dec          = 1'b0;
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
        w_rev_next     = r_rev_phase;
        w_aborted_next = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (start) begin
                    // The live dwell input is loaded here because r_dwell
                    // only takes the new value at this same edge.
                    w_state_next = PH1;
                    w_dir_next   = dir;
                    w_dwell_next = dwell;
                    w_load       = 1'b1;
                    w_load_val   = dwell;
                end
            end

            PH1: begin
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
                // Nothing to back out of yet: go straight to idle.
                if (abort) begin
                    w_state_next   = IDLE;
                    w_aborted_next = 1'b1;
                end else
`endif
                if (w_zero) begin
                    w_state_next = PH2;
                    w_load       = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end

            PH2: begin
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
                if (abort) begin
                    w_state_next = REV;
                    w_rev_next   = PH1;
                    w_load       = 1'b1;
                end else
`endif
                if (w_zero) begin
                    w_state_next = PH3;
                    w_load       = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end

            PH3: begin
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
                if (abort) begin
                    w_state_next = REV;
                    w_rev_next   = PH2;
                    w_load       = 1'b1;
                end else
`endif
                if (w_zero) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end

`ifdef CAR_TRAFFIC_GEN_ABORT_EN
            // Replay PH2 (if entered from PH3) then PH1; abort is ignored.
            REV: begin
                if (w_zero) begin
                    if (r_rev_phase == PH2) begin
                        w_rev_next = PH1;
                        w_load     = 1'b1;
                    end else begin
                        w_state_next   = IDLE;
                        w_aborted_next = 1'b1;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
`endif

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic, computed from the next state so that the registered
    // outputs line up with the registered state.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_next = (w_state_next != IDLE);
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
        w_disp = (w_state_next == REV) ? w_rev_next : w_state_next;
`else
        w_disp = w_state_next;
`endif
        w_sensors_next = phase_sensors(w_disp, w_dir_next);
    end

    assign sensors = r_sensors;
    assign busy    = r_busy;
    assign done    = r_done;
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
    assign aborted = r_aborted;
`endif

endmodule
`default_nettype wire

// File: tb/tb_car_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_traffic_gen
//  Description : Self-checking bench for car_traffic_gen. Directed vector
//                tables, hand-written multi-cycle sequences and a random
//                phase checked against a pass-position reference model.
//                Honours CAR_TRAFFIC_GEN_ABORT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_car_traffic_gen;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          dir;
    logic [DW-1:0] dwell;
    logic [1:0]    sensors;
    logic          busy;
    logic          done;
    logic          abort_v = 1'b0;
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
    logic          aborted;
`endif

    car_traffic_gen #(
        .DWELL_W (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dir     (dir),
        .dwell   (dwell),
        .sensors (sensors),
        .busy    (busy),
        .done    (done)
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
        ,
        .abort   (abort_v),
        .aborted (aborted)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a pass is a position counter m_pos over 3*m_len
    // cycles; the phase is simply m_pos / m_len. Backing out counts the
    // already-crossed cycles down again.
    // ------------------------------------------------------------------
    bit   m_active = 0;
    bit   m_rev    = 0;
    bit   m_done   = 0;
    bit   m_abd    = 0;
    bit   m_dir    = 0;
    int   m_pos    = 0;
    int   m_len    = 1;
    int   m_rev_left = 0;

    function automatic logic [1:0] pat(input int ph, input bit d);
        case (ph)
            0:       return d ? 2'b10 : 2'b01;
            1:       return 2'b11;
            default: return d ? 2'b01 : 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] model_sens();
        if (!m_active) return 2'b00;
        if (m_rev)     return pat((m_rev_left - 1) / m_len, m_dir);
        return pat(m_pos / m_len, m_dir);
    endfunction

    task automatic model_edge();
        int ph;
        if (reset) begin
            m_active = 0; m_rev = 0; m_done = 0; m_abd = 0;
        end else begin
            m_done = 0;
            m_abd  = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_rev = 0; m_pos = 0;
                    m_len = int'(dwell) + 1; m_dir = dir;
                end
            end else if (m_rev) begin
                m_rev_left--;
                if (m_rev_left == 0) begin
                    m_active = 0; m_rev = 0; m_abd = 1;
                end
            end else if (abort_v) begin
                ph = m_pos / m_len;
                if (ph == 0) begin
                    m_active = 0; m_abd = 1;
                end else begin
                    m_rev = 1; m_rev_left = ph * m_len;
                end
            end else begin
                m_pos++;
                if (m_pos == 3 * m_len) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    endtask

    // One clock: model follows the inputs seen at the edge, outputs are
    // sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step_check(input string tag);
        logic [1:0] prev;
        logic       was_rst;
        prev    = sensors;
        was_rst = reset;
        step();
        chk({tag, ".sensors"}, 32'(sensors), 32'(model_sens()));
        chk({tag, ".busy"},    32'(busy),    32'(m_active));
        chk({tag, ".done"},    32'(done),    32'(m_done));
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
        chk({tag, ".aborted"}, 32'(aborted), 32'(m_abd));
        chk({tag, ".excl"},    32'(done & aborted), 32'd0);
`endif
        if (!was_rst)
            chk({tag, ".no_jump"}, 32'((prev ^ sensors) == 2'b11), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          rst;
        logic          st;
        logic          d;
        logic [DW-1:0] dw;
        logic [1:0]    s;
        logic          b;
        logic          dn;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic rst, input logic st, input logic d, input int dw,
                           input logic [1:0] s, input logic b, input logic dn);
        vec_t v;
        v.rst = rst; v.st = st; v.d = d; v.dw = DW'(dw);
        v.s = s; v.b = b; v.dn = dn;
        tbl.push_back(v);
    endtask

    initial begin
        int n_done;
        int n01, n11, n10;
        logic [1:0] exp_ab[10];

        reset = 1'b1; start = 1'b0; dir = 1'b0; dwell = '0;
        step();
        step();
        chk("reset.sensors", 32'(sensors), 32'd0);
        chk("reset.busy",    32'(busy),    32'd0);
        chk("reset.done",    32'(done),    32'd0);
        reset = 1'b0;
        step();

        // Enter pass, dwell=2: nine busy cycles then one done cycle.
        add_vec(0, 1, 1, 2, 2'b10, 1, 0);
        add_vec(0, 0, 1, 2, 2'b10, 1, 0);
        add_vec(0, 0, 1, 2, 2'b10, 1, 0);
        add_vec(0, 0, 1, 2, 2'b11, 1, 0);
        add_vec(0, 0, 1, 2, 2'b11, 1, 0);
        add_vec(0, 0, 1, 2, 2'b11, 1, 0);
        add_vec(0, 0, 1, 2, 2'b01, 1, 0);
        add_vec(0, 0, 1, 2, 2'b01, 1, 0);
        add_vec(0, 0, 1, 2, 2'b01, 1, 0);
        add_vec(0, 0, 1, 2, 2'b00, 0, 1);
        add_vec(0, 0, 1, 2, 2'b00, 0, 0);
        // Exit pass, dwell=0; start during the pass (with other dir) is ignored.
        add_vec(0, 1, 0, 0, 2'b01, 1, 0);
        add_vec(0, 1, 1, 5, 2'b11, 1, 0);
        add_vec(0, 1, 1, 5, 2'b10, 1, 0);
        add_vec(0, 0, 0, 0, 2'b00, 0, 1);
        add_vec(0, 0, 0, 0, 2'b00, 0, 0);
        // Reset in the 2nd PH2 cycle: clear next cycle, no done afterwards.
        add_vec(0, 1, 1, 2, 2'b10, 1, 0);
        add_vec(0, 0, 1, 2, 2'b10, 1, 0);
        add_vec(0, 0, 1, 2, 2'b10, 1, 0);
        add_vec(0, 0, 1, 2, 2'b11, 1, 0);
        add_vec(0, 0, 1, 2, 2'b11, 1, 0);
        add_vec(1, 1, 1, 2, 2'b00, 0, 0);
        add_vec(0, 0, 1, 2, 2'b00, 0, 0);
        add_vec(0, 0, 1, 2, 2'b00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; start = tbl[i].st; dir = tbl[i].d; dwell = tbl[i].dw;
            step();
            chk($sformatf("vec%0d.sensors", i), 32'(sensors), 32'(tbl[i].s));
            chk($sformatf("vec%0d.busy", i),    32'(busy),    32'(tbl[i].b));
            chk($sformatf("vec%0d.done", i),    32'(done),    32'(tbl[i].dn));
        end
        reset = 1'b0; start = 1'b0;

        // Start held high, dwell=0: period of 4 with a single 00/done gap.
        dir = 1'b1; dwell = '0; start = 1'b1; n_done = 0;
        for (int i = 0; i < 16; i++) begin
            step_check("b2b");
            if (sensors == 2'b00) chk("b2b.gap_done", 32'(done), 32'd1);
            if (done) n_done++;
        end
        chk("b2b.done_count", n_done, 32'd4);
        start = 1'b0;
        step_check("b2b_tail");

        // Maximum dwell with the dwell input changed mid-pass.
        dir = 1'b0; dwell = 8'd255; start = 1'b1;
        n01 = 0; n11 = 0; n10 = 0;
        for (int i = 0; i < 3 * 256 + 1; i++) begin
            step_check("maxdw");
            start = 1'b0;
            dwell = 8'd3;
            if (sensors == 2'b01) n01++;
            if (sensors == 2'b11) n11++;
            if (sensors == 2'b10) n10++;
        end
        chk("maxdw.ph1_len", n01, 32'd256);
        chk("maxdw.ph2_len", n11, 32'd256);
        chk("maxdw.ph3_len", n10, 32'd256);
        chk("maxdw.done",    32'(done), 32'd1);

`ifdef CAR_TRAFFIC_GEN_ABORT_EN
        // Enter, dwell=1, abort in the first PH3 cycle: back out via PH2, PH1.
        exp_ab = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
        dir = 1'b1; dwell = 8'd1; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            abort_v = (i == 5);
            step_check("abort");
            start = 1'b0;
            chk($sformatf("abort%0d.sensors", i), 32'(sensors), 32'(exp_ab[i]));
        end
        abort_v = 1'b0;
        chk("abort.aborted", 32'(aborted), 32'd1);
        chk("abort.done",    32'(done),    32'd0);
        step_check("abort_tail");
`else
        exp_ab = '{default: 2'b00};
        chk("idle.sensors", 32'(sensors), 32'(exp_ab[0]));
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            dir   = 1'($urandom);
            dwell = DW'($urandom_range(0, 3));
`ifdef CAR_TRAFFIC_GEN_ABORT_EN
            abort_v = ($urandom_range(0, 19) == 0);
`endif
            step_check("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/car_traffic_gen.md
CAR_TRAFFIC_GEN -- requirements
Module: car_traffic_gen

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, the width of the per-phase dwell count.
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to emit one car pass.
REQ-005 The block SHALL have port dir  input  1  pass direction: 1 = enter, 0 = exit.
REQ-006 The block SHALL have port dwell  input  DWELL_W  phase length minus one, in cycles.
REQ-007 The block SHALL have port sensors  output  2  registered photo-sensor image: bit1 = outer sensor A, bit0 = inner sensor B, 1 = beam blocked.
REQ-008 The block SHALL have port busy  output  1  high while a pass is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when a pass completes.

Function
REQ-010 The block SHALL use FSM states IDLE, PH1, PH2 and PH3, plus REV when CAR_TRAFFIC_GEN_ABORT_EN is defined.
REQ-011 In IDLE, the block SHALL drive sensors to 00 and busy to 0.
REQ-012 In IDLE with start=1 at an edge, the block SHALL latch dir and dwell and enter PH1 on that edge.
REQ-013 An enter pass SHALL drive sensors as PH1=10, PH2=11, PH3=01; an exit pass SHALL drive PH1=01, PH2=11, PH3=10.
REQ-014 Each phase SHALL last exactly dwell+1 cycles; dwell=0 gives 1 cycle per phase, and the maximum dwell gives 2^DWELL_W cycles.
REQ-015 busy SHALL be 1 in every cycle that the state is PH1..PH3 (or REV), so one pass is 3*(dwell+1) cycles.
REQ-016 After the last PH3 cycle, the block SHALL return to IDLE with sensors=00 and done=1 for exactly that one IDLE cycle.
REQ-017 The block SHALL ignore start while busy=1; the dir and dwell values latched at acceptance SHALL hold for the whole pass.
REQ-018 If start=1 during the done cycle, the block SHALL accept it, so back-to-back passes are separated by exactly one 00 cycle.
REQ-019 sensors SHALL never make a direct 10<->01 transition or a 00<->11 transition.

Reset
REQ-020 reset=1 at an edge SHALL force state=IDLE, sensors=00, busy=0, done=0 and the dwell counter to 0.
REQ-021 reset SHALL override start and abort at the same edge.
REQ-022 A reset in the middle of a pass SHALL abandon that pass and SHALL NOT produce a done or aborted pulse.

Configuration
REQ-023 When CAR_TRAFFIC_GEN_ABORT_EN is defined, the block SHALL have port abort  input  1 and port aborted  output  1.
REQ-024 When CAR_TRAFFIC_GEN_ABORT_EN is defined, abort=1 in any PH2 or PH3 cycle SHALL enter REV and step back through the preceding phases in reverse order, each lasting dwell+1 cycles, then return to IDLE with aborted=1 for one cycle and done=0.
REQ-025 When CAR_TRAFFIC_GEN_ABORT_EN is defined, abort=1 in a PH1 cycle SHALL go to IDLE at the next edge with aborted=1.
REQ-026 When CAR_TRAFFIC_GEN_ABORT_EN is defined, abort SHALL be ignored in IDLE and in REV.
REQ-027 When CAR_TRAFFIC_GEN_ABORT_EN is defined, done and aborted SHALL never be high in the same cycle.
REQ-028 Without CAR_TRAFFIC_GEN_ABORT_EN, the abort and aborted ports and the REV state SHALL be absent, and behaviour SHALL be exactly REQ-010..REQ-019.

Structure
REQ-029 Package car_traffic_pkg SHALL hold the FSM state enum and the constants SNS_CLEAR=00, SNS_A=10, SNS_AB=11 and SNS_B=01.
REQ-030 The block SHALL contain one sub-module, dwell_timer, a loadable down-counter with a zero flag.

Verification
REQ-031 The bench SHALL cover: dir=1, dwell=2, start pulse -> sensors 10,10,10,11,11,11,01,01,01, then 00 with done=1; busy high for 9 cycles.
REQ-032 The bench SHALL cover: dir=0, dwell=0 -> sensors 01,11,10, then 00 with done=1; a start during the pass is ignored.
REQ-033 The bench SHALL cover: start held high, dwell=0 -> passes repeat with exactly one 00/done cycle between them.
REQ-034 The bench SHALL cover: reset asserted in the 2nd PH2 cycle -> sensors 00 the next cycle, no done, busy=0.
REQ-035 The bench SHALL cover (ABORT_EN): enter, dwell=1, abort in the 1st PH3 cycle -> sensors 01,11,11,10,10, then 00 with aborted=1 and done=0.
REQ-036 The bench SHALL cover: dwell=255 -> each phase lasts 256 cycles, and changing dwell mid-pass has no effect.
